// File: rtl/transport_send_if.sv
// Session-word input and network-byte output handshakes of the transmit transport stage.
// master = session/network side driving words and out_ready; slave = transport_send.
interface transport_send_if;
    logic        in_valid;
    logic [1:0]  in_type;
    logic [15:0] in_data;
    logic        in_ready;
    logic        bad_type;
    logic        out_valid;
    logic [7:0]  out_byte;
    logic        out_sop;
    logic        out_ready;
    logic        busy;

    modport master (
        output in_valid, in_type, in_data, out_ready,
        input  in_ready, bad_type, out_valid, out_byte, out_sop, busy
    );

    modport slave (
        input  in_valid, in_type, in_data, out_ready,
        output in_ready, bad_type, out_valid, out_byte, out_sop, busy
    );
endinterface

// File: rtl/transport_send.sv
// Packs session words into fixed PACKET_SIZE-byte control/audio packets; header registered one edge after the enabling word.
// Bytes advance only on out_valid&&out_ready; audio stalls while buffer full/locked, control stalls while slot occupied.
module transport_send #(
    parameter int PACKET_SIZE = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    transport_send_if.slave  bus
);
    localparam int SAMPLES = (PACKET_SIZE - 2) / 2;
    localparam int CW      = $clog2(PACKET_SIZE);
    localparam int NW      = $clog2(SAMPLES + 1);
    localparam int IW      = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;

    localparam logic [CW-1:0] LAST_BYTE = CW'(PACKET_SIZE - 1);
    localparam logic [CW-1:0] LAST_AUD  = CW'(2 * SAMPLES);
    localparam logic [CW-1:0] LAST_CTL  = CW'(2);
    localparam logic [NW-1:0] FULL_CNT  = NW'(SAMPLES);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, PAD} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_is_ctrl, w_is_ctrl_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt, w_inc, w_last;
    logic          r_out_vld, w_out_vld_nxt;
    logic [7:0]    r_out_byte, w_out_byte_nxt;
    logic          r_out_sop, w_out_sop_nxt;
    logic          r_bad;

    logic [NW-1:0] r_count;
    logic [15:0]   r_buf [SAMPLES];
    logic [15:0]   r_ctrl_word;
    logic          r_ctrl_pend;

    logic          w_in_rdy, w_acc, w_acc_ctl, w_acc_aud, w_acc_bad;
    logic          w_xfer, w_locked, w_full, w_pkt_done;
    logic [IW-1:0] w_sidx;
    logic [7:0]    w_payload;

    assign w_xfer     = r_out_vld & bus.out_ready;
    assign w_locked   = (r_state != IDLE) & ~r_is_ctrl;
    assign w_full     = (r_count == FULL_CNT);
    assign w_pkt_done = w_xfer & (r_cnt == LAST_BYTE);

    always_comb begin
        w_in_rdy = 1'b1;
        case (bus.in_type)
            2'b01:   w_in_rdy = ~r_ctrl_pend;
            2'b10:   w_in_rdy = ~w_full & ~w_locked;
            default: w_in_rdy = 1'b1;
        endcase
    end

    assign w_acc     = bus.in_valid & w_in_rdy;
    assign w_acc_ctl = w_acc & (bus.in_type == 2'b01);
    assign w_acc_aud = w_acc & (bus.in_type == 2'b10);
    assign w_acc_bad = w_acc & ((bus.in_type == 2'b00) | (bus.in_type == 2'b11));

    // Byte r_cnt+1 of an audio packet belongs to sample r_cnt/2; odd byte numbers carry the MSB.
    assign w_inc  = r_cnt + 1'b1;
    assign w_sidx = IW'(r_cnt >> 1);
    assign w_last = r_is_ctrl ? LAST_CTL : LAST_AUD;

    always_comb begin
        w_payload = 8'h00;
        if (r_is_ctrl)
            w_payload = (w_inc == CW'(1)) ? r_ctrl_word[15:8] : r_ctrl_word[7:0];
        else
            w_payload = w_inc[0] ? r_buf[w_sidx][15:8] : r_buf[w_sidx][7:0];
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_is_ctrl_nxt  = r_is_ctrl;
        w_cnt_nxt      = r_cnt;
        w_out_vld_nxt  = r_out_vld;
        w_out_byte_nxt = r_out_byte;
        w_out_sop_nxt  = r_out_sop;
        case (r_state)
            IDLE: begin
                if (r_ctrl_pend || w_full) begin
                    w_state_nxt    = HEADER;
                    w_is_ctrl_nxt  = r_ctrl_pend;
                    w_cnt_nxt      = '0;
                    w_out_vld_nxt  = 1'b1;
                    w_out_sop_nxt  = 1'b1;
                    w_out_byte_nxt = r_ctrl_pend ? 8'h40 : 8'h80;
                end
            end
            HEADER, PAYLOAD, PAD: begin
                if (w_pkt_done) begin
                    w_state_nxt    = IDLE;
                    w_cnt_nxt      = '0;
                    w_out_vld_nxt  = 1'b0;
                    w_out_sop_nxt  = 1'b0;
                    w_out_byte_nxt = 8'h00;
                end else if (w_xfer) begin
                    w_cnt_nxt     = w_inc;
                    w_out_sop_nxt = 1'b0;
                    if (w_inc > w_last) begin
                        w_state_nxt    = PAD;
                        w_out_byte_nxt = 8'h00;
                    end else begin
                        w_state_nxt    = PAYLOAD;
                        w_out_byte_nxt = w_payload;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_is_ctrl  <= 1'b0;
            r_cnt      <= '0;
            r_out_vld  <= 1'b0;
            r_out_byte <= 8'h00;
            r_out_sop  <= 1'b0;
            r_bad      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_is_ctrl  <= w_is_ctrl_nxt;
            r_cnt      <= w_cnt_nxt;
            r_out_vld  <= w_out_vld_nxt;
            r_out_byte <= w_out_byte_nxt;
            r_out_sop  <= w_out_sop_nxt;
            r_bad      <= w_acc_bad;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count     <= '0;
            r_ctrl_word <= 16'h0000;
            r_ctrl_pend <= 1'b0;
            for (int i = 0; i < SAMPLES; i++) r_buf[i] <= 16'h0000;
        end else begin
            if (w_pkt_done && !r_is_ctrl) begin
                r_count <= '0;
            end else if (w_acc_aud) begin
                r_buf[r_count] <= bus.in_data;
                r_count        <= r_count + 1'b1;
            end
            if (w_acc_ctl) begin
                r_ctrl_word <= bus.in_data;
                r_ctrl_pend <= 1'b1;
            end else if (w_pkt_done && r_is_ctrl) begin
                r_ctrl_pend <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_rdy;
    assign bus.bad_type  = r_bad;
    assign bus.out_valid = r_out_vld;
    assign bus.out_byte  = r_out_byte;
    assign bus.out_sop   = r_out_sop;
    assign bus.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_transport_send.sv
// Directed bench for transport_send with PACKET_SIZE=16 (7 audio samples per packet).
module tb_transport_send;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0]  cap_b [16];
    logic [15:0] cap_sop;
    int          cap_n, cap_unst, cap_rdy_hi;

    transport_send_if bus ();

    transport_send #(.PACKET_SIZE(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] t, input logic [15:0] d);
        int cyc = 0;
        bus.in_valid = 1'b1;
        bus.in_type  = t;
        bus.in_data  = d;
        #1;
        while (!bus.in_ready && cyc < 100) begin
            tick();
            cyc++;
        end
        if (!bus.in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=%0b required 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Sample i = {base+2i+1, base+2i+2}, so packet byte n (1..14) equals base+n.
    task automatic send_samples(input logic [7:0] base, input int first, input int last);
        for (int i = first; i <= last; i++)
            send(2'b10, {base + 8'(2*i+1), base + 8'(2*i+2)});
    endtask

    task automatic collect(input bit toggle);
        logic pv, pr;
        logic [7:0] pb;
        int cyc;
        cap_n = 0; cap_unst = 0; cap_rdy_hi = 0; cap_sop = '0;
        pv = 1'b0; pr = 1'b1; pb = 8'h00; cyc = 0;
        while (cap_n < 16 && cyc < 400) begin
            bus.out_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (pv && !pr && (bus.out_valid !== 1'b1 || bus.out_byte !== pb)) cap_unst++;
            if (bus.out_valid && bus.in_ready) cap_rdy_hi++;
            if (bus.out_valid && bus.out_ready) begin
                cap_b[cap_n]   = bus.out_byte;
                cap_sop[cap_n] = bus.out_sop;
                cap_n++;
            end
            pv = bus.out_valid; pr = bus.out_ready; pb = bus.out_byte;
            tick();
            cyc++;
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_type = 2'b10; bus.in_data = 16'h0; bus.out_ready = 1'b1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_byte, bus.out_sop, bus.bad_type, bus.busy} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: vld=%0b byte=%02h sop=%0b bad=%0b busy=%0b required all 0",
                     bus.out_valid, bus.out_byte, bus.out_sop, bus.bad_type, bus.busy);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_audio_ready: got %0b required 1", bus.in_ready);
        end
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_control();
        logic [7:0] e;
        int bad_busy = 0;
        send(2'b01, 16'hBEEF);
        checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL ctl_latency_k: busy=%0b vld=%0b required 0 0", bus.busy, bus.out_valid);
        end
        tick();
        for (int i = 0; i < 16; i++) begin
            e = (i == 0) ? 8'h40 : (i == 1) ? 8'hBE : (i == 2) ? 8'hEF : 8'h00;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_byte !== e || bus.out_sop !== (i == 0)) begin
                errors++;
                $display("FAIL ctl_byte%0d: vld=%0b byte=%02h sop=%0b required 1 %02h %0b",
                         i, bus.out_valid, bus.out_byte, bus.out_sop, e, (i == 0));
            end
            if (bus.busy !== 1'b1) bad_busy++;
            tick();
        end
        checks++;
        if (bad_busy != 0) begin
            errors++; $display("FAIL ctl_busy: low in %0d of 16 cycles required 0", bad_busy);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL ctl_end: vld=%0b busy=%0b required 0 0", bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_audio();
        logic [7:0] e;
        send_samples(8'h00, 0, 6);
        bus.in_valid = 1'b1; bus.in_type = 2'b10; bus.in_data = 16'hA1A2;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL aud_full_stall: in_ready=%0b required 0", bus.in_ready);
        end
        collect(1'b0);
        checks++;
        if (cap_n != 16 || cap_sop !== 16'h0001 || cap_rdy_hi != 0) begin
            errors++;
            $display("FAIL aud_pkt1_shape: n=%0d sop=%04h rdy_hi=%0d required 16 0001 0", cap_n, cap_sop, cap_rdy_hi);
        end
        for (int n = 0; n < 16; n++) begin
            e = (n == 0) ? 8'h80 : (n == 15) ? 8'h00 : 8'(n);
            checks++;
            if (cap_b[n] !== e) begin
                errors++; $display("FAIL aud_pkt1_byte%0d: got %02h required %02h", n, cap_b[n], e);
            end
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL aud_unlock: in_ready=%0b required 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        send_samples(8'hA0, 1, 6);
        collect(1'b0);
        for (int n = 0; n < 4; n++) begin
            e = (n == 0) ? 8'h80 : 8'hA0 + 8'(n);
            checks++;
            if (cap_n != 16 || cap_b[n] !== e) begin
                errors++; $display("FAIL aud_pkt2_byte%0d: got %02h (n=%0d) required %02h", n, cap_b[n], cap_n, e);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] e;
        send_samples(8'h00, 0, 6);
        collect(1'b1);
        checks++;
        if (cap_n != 16 || cap_unst != 0) begin
            errors++; $display("FAIL bp_transfers: n=%0d unstable=%0d required 16 0", cap_n, cap_unst);
        end
        for (int n = 0; n < 16; n++) begin
            e = (n == 0) ? 8'h80 : (n == 15) ? 8'h00 : 8'(n);
            checks++;
            if (cap_b[n] !== e) begin
                errors++; $display("FAIL bp_byte%0d: got %02h required %02h", n, cap_b[n], e);
            end
        end
    endtask

    task automatic test_ctrl_audio_priority();
        logic [7:0] e;
        send_samples(8'h30, 0, 5);
        send(2'b01, 16'h1234);
        send_samples(8'h30, 6, 6);
        collect(1'b0);
        for (int n = 0; n < 4; n++) begin
            e = (n == 0) ? 8'h40 : (n == 1) ? 8'h12 : (n == 2) ? 8'h34 : 8'h00;
            checks++;
            if (cap_n != 16 || cap_b[n] !== e) begin
                errors++; $display("FAIL prio_ctl_byte%0d: got %02h (n=%0d) required %02h", n, cap_b[n], cap_n, e);
            end
        end
        collect(1'b0);
        for (int n = 0; n < 16; n += 7) begin
            e = (n == 0) ? 8'h80 : (n == 14) ? 8'h3E : 8'h30 + 8'(n);
            checks++;
            if (cap_n != 16 || cap_b[n] !== e) begin
                errors++; $display("FAIL prio_aud_byte%0d: got %02h (n=%0d) required %02h", n, cap_b[n], cap_n, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] e;
        int cyc = 0;
        send_samples(8'h00, 0, 6);
        while (!bus.out_valid && cyc < 50) begin tick(); cyc++; end
        repeat (6) tick();
        checks++;
        if (bus.out_byte !== 8'h06) begin
            errors++; $display("FAIL rst_pre_byte6: got %02h required 06", bus.out_byte);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_byte, bus.out_sop, bus.busy} !== 11'h000) begin
            errors++;
            $display("FAIL rst_mid_outputs: vld=%0b byte=%02h sop=%0b busy=%0b required all 0",
                     bus.out_valid, bus.out_byte, bus.out_sop, bus.busy);
        end
        tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_release: busy=%0b vld=%0b required 0 0", bus.busy, bus.out_valid);
        end
        send_samples(8'h20, 0, 5);
        repeat (4) tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_buf_empty: vld=%0b after 6 samples required 0", bus.out_valid);
        end
        send_samples(8'h20, 6, 6);
        collect(1'b0);
        for (int n = 0; n < 16; n++) begin
            e = (n == 0) ? 8'h80 : (n == 15) ? 8'h00 : 8'h20 + 8'(n);
            checks++;
            if (cap_b[n] !== e) begin
                errors++; $display("FAIL rst_clean_byte%0d: got %02h required %02h", n, cap_b[n], e);
            end
        end
    endtask

    task automatic test_bad_type();
        logic [7:0] e;
        send_samples(8'h50, 0, 5);
        bus.in_valid = 1'b1; bus.in_type = 2'b11; bus.in_data = 16'hFFFF;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bad_ready: got %0b required 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.bad_type !== 1'b1) begin
            errors++; $display("FAIL bad_pulse: got %0b required 1", bus.bad_type);
        end
        tick();
        checks++;
        if (bus.bad_type !== 1'b0) begin
            errors++; $display("FAIL bad_pulse_end: got %0b required 0", bus.bad_type);
        end
        repeat (4) tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL bad_no_packet: vld=%0b busy=%0b required 0 0", bus.out_valid, bus.busy);
        end
        send_samples(8'h50, 6, 6);
        collect(1'b0);
        for (int n = 0; n < 16; n++) begin
            e = (n == 0) ? 8'h80 : (n == 15) ? 8'h00 : 8'h50 + 8'(n);
            checks++;
            if (cap_b[n] !== e) begin
                errors++; $display("FAIL bad_count_byte%0d: got %02h required %02h", n, cap_b[n], e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_control();
        test_audio();
        test_backpressure();
        test_ctrl_audio_priority();
        test_reset_mid();
        test_bad_type();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
